// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Issues one fetch address per advancing cycle, holds it under stall,
// takes two prioritised redirects (flush over jump) and latches a redirect
// that arrives while stalled. Optional direct-mapped BTB for taken-branch
// prediction, enabled by defining PC_GEN_BTB_EN.
module pc_gen #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                STEP      = 4,
   parameter int                BTB_DEPTH = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_tar,
   input  logic              jmp_tak,
   input  logic [ADDR_W-1:0] jmp_tar,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_tar,
   output logic [ADDR_W-1:0] output_pc,
   output logic              output_vld,
   output logic              pred_tak
);

   logic              w_adv;
   logic [ADDR_W-1:0] w_sel;
   logic [ADDR_W-1:0] w_seq;
   logic              w_hit;
   logic [ADDR_W-1:0] w_btb_tar;

   logic [ADDR_W-1:0] r_pc;
   logic              r_pend_vld;
   logic [ADDR_W-1:0] r_pend_tar;
   logic [ADDR_W-1:0] r_out_pc;
   logic              r_out_vld;
   logic              r_pred_tak;

   assign w_adv = rdy_in & ~stall;
   assign w_sel = flush      ? flush_tar  :
                  jmp_tak    ? jmp_tar    :
                  r_pend_vld ? r_pend_tar : r_pc;
   // wraps modulo 2^ADDR_W by construction
   assign w_seq = w_sel + ADDR_W'(STEP);

`ifdef PC_GEN_BTB_EN
   localparam int SH = $clog2(STEP);
   localparam int IW = $clog2(BTB_DEPTH);
   localparam int TW = ADDR_W - SH - IW;

   logic [BTB_DEPTH-1:0] r_btb_vld;
   logic [TW-1:0]        r_btb_tag [BTB_DEPTH];
   logic [ADDR_W-1:0]    r_btb_tar [BTB_DEPTH];
   logic [IW-1:0]        w_rd_idx;
   logic [IW-1:0]        w_wr_idx;
   logic                 w_btb_wr;
   logic                 w_unused;

   assign w_rd_idx  = w_sel[SH+IW-1:SH];
   assign w_wr_idx  = upd_pc[SH+IW-1:SH];
   assign w_btb_wr  = upd_en & rdy_in;
   // lookup reads the pre-write contents; a same-cycle write lands next cycle
   assign w_hit     = r_btb_vld[w_rd_idx] &&
                      (r_btb_tag[w_rd_idx] == w_sel[ADDR_W-1:SH+IW]);
   assign w_btb_tar = r_btb_tar[w_rd_idx];
   // offset bits of the update address never reach the BTB
   assign w_unused  = ^upd_pc;

   // BTB valid bits: cleared by reset, set on update
   always_ff @(posedge clk_in) begin
      if (rst_in)
         r_btb_vld <= '0;
      else if (w_btb_wr)
         r_btb_vld[w_wr_idx] <= 1'b1;
   end

   // BTB tag/target storage: no reset needed, qualified by valid bits
   always_ff @(posedge clk_in) begin
      if (w_btb_wr) begin
         r_btb_tag[w_wr_idx] <= upd_pc[ADDR_W-1:SH+IW];
         r_btb_tar[w_wr_idx] <= upd_tar;
      end
   end
`else
   logic w_unused;

   assign w_hit     = 1'b0;
   assign w_btb_tar = '0;
   // update port has no consumer without the BTB
   assign w_unused  = ^{upd_en, upd_pc, upd_tar};
`endif

   // fetch address, prediction and pending-redirect state
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pc       <= RESET_PC;
         r_out_pc   <= RESET_PC;
         r_out_vld  <= 1'b0;
         r_pred_tak <= 1'b0;
         r_pend_vld <= 1'b0;
         r_pend_tar <= '0;
      end else if (w_adv) begin
         r_out_pc   <= w_sel;
         r_out_vld  <= 1'b1;
         r_pend_vld <= 1'b0;
         r_pc       <= w_hit ? w_btb_tar : w_seq;
         r_pred_tak <= w_hit;
      end else if (rdy_in && (flush || jmp_tak)) begin
         // stalled: remember the newest redirect, held address is wrong-path
         r_pend_vld <= 1'b1;
         r_pend_tar <= flush ? flush_tar : jmp_tar;
         r_out_vld  <= 1'b0;
      end
   end

   assign output_pc  = r_out_pc;
   assign output_vld = r_out_vld;
   assign pred_tak   = r_pred_tak;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (RESET_PC=0x100, STEP=4, BTB_DEPTH=16).
// BTB expectations follow PC_GEN_BTB_EN when it is defined for the bench too.
module tb_pc_gen;
   logic        clk_in = 0;
   logic        rst_in, rdy_in, stall, flush, jmp_tak, upd_en;
   logic [31:0] flush_tar, jmp_tar, upd_pc, upd_tar;
   logic [31:0] output_pc;
   logic        output_vld, pred_tak;
   int          n_chk = 0;
   int          n_err = 0;

   pc_gen #(.ADDR_W(32), .RESET_PC(32'h100), .STEP(4), .BTB_DEPTH(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall(stall),
      .flush(flush), .flush_tar(flush_tar), .jmp_tak(jmp_tak), .jmp_tar(jmp_tar),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_tar(upd_tar),
      .output_pc(output_pc), .output_vld(output_vld), .pred_tak(pred_tak));

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // check pc / vld / pred together after one clock
   task automatic stepchk(input string tag, input logic [31:0] pc, input logic v, input logic p);
      step();
      chk({tag, ".pc"}, output_pc, pc);
      chk({tag, ".vld"}, {31'd0, output_vld}, {31'd0, v});
      chk({tag, ".pred"}, {31'd0, pred_tak}, {31'd0, p});
   endtask

`ifdef PC_GEN_BTB_EN
   localparam logic BTB = 1'b1;
`else
   localparam logic BTB = 1'b0;
`endif

   initial begin
      rst_in = 1; rdy_in = 1; stall = 0; flush = 0; jmp_tak = 0; upd_en = 0;
      flush_tar = 0; jmp_tar = 0; upd_pc = 0; upd_tar = 0;
      step();
      stepchk("reset", 32'h100, 0, 0);

      // free run
      rst_in = 0;
      stepchk("run0", 32'h100, 1, 0);
      stepchk("run1", 32'h104, 1, 0);
      stepchk("run2", 32'h108, 1, 0);

      // jump while advancing
      jmp_tak = 1; jmp_tar = 32'h2000;
      stepchk("jmp0", 32'h2000, 1, 0);
      jmp_tak = 0;
      stepchk("jmp1", 32'h2004, 1, 0);

      // flush beats jump; jump is dropped
      flush = 1; flush_tar = 32'h80; jmp_tak = 1; jmp_tar = 32'h2000;
      stepchk("fl0", 32'h80, 1, 0);
      flush = 0; jmp_tak = 0;
      stepchk("fl1", 32'h84, 1, 0);
      stepchk("fl2", 32'h88, 1, 0);

      // stall 3 cycles, jump then flush while stalled
      stall = 1;
      stepchk("st0", 32'h88, 1, 0);
      jmp_tak = 1; jmp_tar = 32'h400;
      stepchk("st1", 32'h88, 0, 0);
      jmp_tak = 0; flush = 1; flush_tar = 32'h800;
      stepchk("st2", 32'h88, 0, 0);
      flush = 0; stall = 0;
      stepchk("st3", 32'h800, 1, 0);
      stepchk("st4", 32'h804, 1, 0);

      // fresh redirect on release overrides the pending one
      stall = 1; jmp_tak = 1; jmp_tar = 32'h500;
      stepchk("ov0", 32'h804, 0, 0);
      stall = 0; jmp_tar = 32'h600;
      stepchk("ov1", 32'h600, 1, 0);
      jmp_tak = 0;
      stepchk("ov2", 32'h604, 1, 0);

      // wrap
      jmp_tak = 1; jmp_tar = 32'hFFFF_FFFC;
      stepchk("wr0", 32'hFFFF_FFFC, 1, 0);
      jmp_tak = 0;
      stepchk("wr1", 32'h0, 1, 0);

      // rdy low: jump and BTB update ignored
      rdy_in = 0; jmp_tak = 1; jmp_tar = 32'h3000;
      upd_en = 1; upd_pc = 32'h8; upd_tar = 32'h9000;
      stepchk("rdy0", 32'h0, 1, 0);
      stepchk("rdy1", 32'h0, 1, 0);
      rdy_in = 1; jmp_tak = 0; upd_en = 0;
      stepchk("rdy2", 32'h4, 1, 0);
      stepchk("rdy3", 32'h8, 1, 0);
      stepchk("rdy4", 32'hC, 1, 0);

      // reset mid-stall discards pending redirect
      stall = 1; jmp_tak = 1; jmp_tar = 32'h700;
      stepchk("rs0", 32'hC, 0, 0);
      rst_in = 1;
      stepchk("rs1", 32'h100, 0, 0);
      rst_in = 0; stall = 0; jmp_tak = 0;
      stepchk("rs2", 32'h100, 1, 0);
      stepchk("rs3", 32'h104, 1, 0);

      // BTB: record 0x10 -> 0x40, then fetch 0x10
      upd_en = 1; upd_pc = 32'h10; upd_tar = 32'h40;
      stepchk("bt0", 32'h108, 1, 0);
      upd_en = 0; jmp_tak = 1; jmp_tar = 32'h10;
      stepchk("bt1", 32'h10, 1, BTB);
      jmp_tak = 0;
      stepchk("bt2", BTB ? 32'h40 : 32'h14, 1, 0);
      stepchk("bt3", BTB ? 32'h44 : 32'h18, 1, 0);
      // alias at 0x10 + 4*16: same index, different tag
      jmp_tak = 1; jmp_tar = 32'h50;
      stepchk("al0", 32'h50, 1, 0);
      jmp_tak = 0;
      stepchk("al1", 32'h54, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator for the EPU front end, sitting between the redirect sources (execute-stage branch resolution, exception/flush logic) and the instruction fetch port. It issues one fetch address per advancing cycle and holds it under stall. It accepts two prioritised redirects, latches any redirect that arrives while stalled, and can optionally predict taken branches with a small direct-mapped branch target buffer (BTB).

## Interface
- `ADDR_W`, 32, PC width in bits.
- `RESET_PC`, 32'h0, first fetch address after reset.
- `STEP`, 4, sequential increment; power of two.
- `BTB_DEPTH`, 16, BTB entries; power of two, ≥2.

- `clk_in`  input  1  clock; all state updates on rising edge.
- `rst_in`  input  1  synchronous, active-high reset.
- `rdy_in`  input  1  global enable; when low, no state changes except reset.
- `stall`  input  1  downstream not accepting; hold current fetch address.
- `flush`  input  1  highest-priority redirect (exception/pipeline flush).
- `flush_tar`  input  ADDR_W  flush target.
- `jmp_tak`  input  1  resolved taken branch/jump redirect.
- `jmp_tar`  input  ADDR_W  branch target.
- `upd_en`  input  1  BTB write strobe from execute.
- `upd_pc`  input  ADDR_W  branch instruction address to record.
- `upd_tar`  input  ADDR_W  its taken target.
- `output_pc`  output  ADDR_W  current fetch address (registered).
- `output_vld`  output  1  `output_pc` is a valid fetch request.
- `pred_tak`  output  1  `output_pc` hit in the BTB; the next fetch is the predicted target.

## Operation
- Internal state: `pc` (next sequential/predicted address), `pend_vld`/`pend_tar` (latched redirect), BTB arrays (valid, tag, target).
- Advance condition `adv = rdy_in & ~stall`.
- Select: `sel = flush ? flush_tar : jmp_tak ? jmp_tar : pend_vld ? pend_tar : pc`.
- On `adv`:
  - `output_pc <= sel`, `output_vld <= 1`, `pend_vld <= 0`.
  - `pc <= btb_hit(sel) ? btb_tar(sel) : sel + STEP`.
  - `pred_tak <= btb_hit(sel)`.
- On `rdy_in & stall`:
  - `output_pc` and `pred_tak` hold.
  - If `flush | jmp_tak`: `pend_vld <= 1`, `pend_tar <= flush ? flush_tar : jmp_tar`, `output_vld <= 0` (held address is wrong-path).
  - A newer redirect overwrites an older pending one.
  - Otherwise `output_vld` holds.
- With `rdy_in` low, all inputs are ignored, including redirects and BTB updates.
- BTB indexing:
  - Index = `addr[log2(STEP)+log2(BTB_DEPTH)-1 : log2(STEP)]`.
  - Tag = `addr[ADDR_W-1 : log2(STEP)+log2(BTB_DEPTH)]`.
  - Hit = valid & tag match.
- BTB update:
  - When `upd_en & rdy_in`, the indexed entry is written (valid=1, tag, target), overwriting any occupant.
  - The lookup of the same index in the same cycle sees the old contents.
- Arithmetic: `sel + STEP` wraps modulo 2^ADDR_W with no overflow flag.
- Reset values: `output_pc = RESET_PC`, `output_vld = 0`, `pred_tak = 0`, `pc = RESET_PC`, `pend_vld = 0`, all BTB valid bits = 0. Target/tag arrays need no reset.
- Reset mid-stall discards any pending redirect.

## Timing
- First valid fetch: reset released at cycle 0 with `adv` → cycle 1 `output_pc = RESET_PC`, `output_vld = 1`.
- Redirect latency:
  - Redirect asserted with `adv` in cycle t → `output_pc = target` at t+1, `target+STEP` (or BTB target) at t+2.
  - No bubble cycle.
- Redirect during stall: applied on the first `adv` cycle, unless a fresh redirect in that cycle overrides it.
- Simultaneous `flush` and `jmp_tak`: `flush` wins. The `jmp_tak` is dropped, not queued.
- BTB write visible to lookups from the following cycle.
- Single cycle between `sel` and registered outputs. Critical path: `sel` mux → BTB read/compare → `pc` mux.

## Configuration
- `PC_GEN_BTB_EN` defined: BTB is instantiated as described.
- Undefined:
  - No BTB storage.
  - `btb_hit` is constant 0, so `pc <= sel + STEP` and `pred_tak` is constant 0.
  - `upd_en`/`upd_pc`/`upd_tar` are ignored.
  - All other behaviour is identical.

## Test plan
- Reset then free-run (RESET_PC=0x100, no stall) → `output_pc` sequence 0x100, 0x104, 0x108; `output_vld` 0 then 1 from cycle 1.
- `jmp_tak`=1, `jmp_tar`=0x2000 while advancing → next `output_pc` = 0x2000, then 0x2004; `flush_tar`=0x80 in the same cycle with `flush`=1 → 0x80 instead.
- Stall 3 cycles; assert `jmp_tak` (0x400) in cycle 1, then `flush` (0x800) in cycle 2 of the stall → `output_vld` drops, `output_pc` held; first output after stall is 0x800.
- Wrap: ADDR_W=32, `jmp_tar`=0xFFFFFFFC → outputs 0xFFFFFFFC, then 0x00000000.
- BTB (macro defined): `upd_en` with `upd_pc`=0x10, `upd_tar`=0x40, then fetch reaches 0x10 → `pred_tak`=1 with `output_pc`=0x10, next `output_pc`=0x40. Aliasing address 0x10+STEP·BTB_DEPTH → no hit (tag mismatch).
- `rdy_in` low for 2 cycles with `jmp_tak` and `upd_en` pulsed → no output change, no pending redirect, no BTB write.
